// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-wide memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StReady
    } rd_state_e;

    localparam int unsigned CntW = 4;
    localparam logic [7:0] OorRdData = 8'h00;

endpackage

// File: rtl/mem_array.sv
// Single-port byte RAM: synchronous write, asynchronous read, loader has write priority.
module mem_array #(
    parameter int unsigned AddrW = 10
) (
    input  logic             clk_i,
    input  logic             load_we_i,
    input  logic [AddrW-1:0] load_addr_i,
    input  logic [7:0]       load_data_i,
    input  logic             cpu_we_i,
    input  logic [AddrW-1:0] cpu_addr_i,
    input  logic [7:0]       cpu_data_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    localparam int unsigned Depth = 2 ** AddrW;

    logic [7:0]       mem_q [Depth];
    logic             we;
    logic [AddrW-1:0] waddr;
    logic [7:0]       wdata;

    always_comb begin
        we    = load_we_i | cpu_we_i;
        waddr = load_we_i ? load_addr_i : cpu_addr_i;
        wdata = load_we_i ? load_data_i : cpu_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory target: read FSM with programmable latency, loader write port,
// sticky error/conflict flags.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [7:0]  data_in,
    input  logic        memory_write_en,
    input  logic        memory_read_en,
    output logic [7:0]  data_out,
    output logic        memory_ready,
    input  logic        load_valid,
    input  logic [31:0] load_addr,
    input  logic [7:0]  load_data,
    output logic        addr_err,
    output logic        conflict
);

    rd_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rd_addr_q, rd_addr_d;
    logic [7:0]      data_q, data_d;
    logic            addr_err_q, addr_err_d;
    logic            conflict_q, conflict_d;

    logic       cpu_in_range, load_in_range, rd_in_range;
    logic       load_commit, cpu_commit, write_hit;
    logic [7:0] rdata;

    always_comb begin
        cpu_in_range  = (addr[31:ADDR_W] == '0);
        load_in_range = (load_addr[31:ADDR_W] == '0);
        rd_in_range   = (rd_addr_q[31:ADDR_W] == '0);
        load_commit   = load_valid && load_in_range;
        // Any loader strobe wins the port, even one that is itself dropped.
        cpu_commit    = memory_write_en && cpu_in_range && !load_valid;
        write_hit     = (load_commit && (load_addr == rd_addr_q)) ||
                        (cpu_commit && (addr == rd_addr_q));
    end

    mem_array #(
        .AddrW (ADDR_W)
    ) u_mem_array (
        .clk_i       (clk),
        .load_we_i   (load_commit),
        .load_addr_i (load_addr[ADDR_W-1:0]),
        .load_data_i (load_data),
        .cpu_we_i    (cpu_commit),
        .cpu_addr_i  (addr[ADDR_W-1:0]),
        .cpu_data_i  (data_in),
        .raddr_i     (rd_addr_q[ADDR_W-1:0]),
        .rdata_o     (rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        data_d    = data_q;

        if (!memory_read_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StWait;
                    rd_addr_d = addr;
                    cnt_d     = CntW'(READ_LATENCY - 1);
                end
                StWait, StReady: begin
                    if ((addr != rd_addr_q) || write_hit) begin
                        state_d   = StWait;
                        rd_addr_d = addr;
                        cnt_d     = CntW'(READ_LATENCY - 1);
                    end else if (state_q == StWait) begin
                        if (cnt_q == '0) begin
                            data_d  = rd_in_range ? rdata : OorRdData;
                            state_d = StReady;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        addr_err_d = addr_err_q ||
                     ((memory_read_en || memory_write_en) && !cpu_in_range) ||
                     (load_valid && !load_in_range);
        conflict_d = conflict_q || (load_valid && memory_write_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            data_q     <= 8'h00;
            addr_err_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            data_q     <= data_d;
            addr_err_q <= addr_err_d;
            conflict_q <= conflict_d;
        end
    end

    // Combinational so an address change drops ready before the initiator can sample it.
    assign memory_ready = (state_q == StReady) && memory_read_en && (addr == rd_addr_q);
    assign data_out     = data_q;
    assign addr_err     = addr_err_q;
    assign conflict     = conflict_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected bytes queued at request, checked at ready.
module tb_mem_responder;

    localparam int unsigned AddrW = 10;
    localparam int unsigned Lat   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [7:0]  data_in = '0;
    logic        memory_write_en = 1'b0;
    logic        memory_read_en = 1'b0;
    logic [7:0]  data_out;
    logic        memory_ready;
    logic        load_valid = 1'b0;
    logic [31:0] load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        addr_err;
    logic        conflict;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [7:0]  model [1 << AddrW];
    logic [7:0]  exp_q [$];

    mem_responder #(
        .ADDR_W       (AddrW),
        .READ_LATENCY (Lat)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .addr            (addr),
        .data_in         (data_in),
        .memory_write_en (memory_write_en),
        .memory_read_en  (memory_read_en),
        .data_out        (data_out),
        .memory_ready    (memory_ready),
        .load_valid      (load_valid),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .addr_err        (addr_err),
        .conflict        (conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] a);
        if (a[31:AddrW] != '0) return 8'h00;
        return model[a[AddrW-1:0]];
    endfunction

    task automatic load_write(input logic [31:0] a, input logic [7:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
        if (a[31:AddrW] == '0) model[a[AddrW-1:0]] = d;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
        memory_write_en = 1'b1;
        addr            = a;
        data_in         = d;
        tick();
        memory_write_en = 1'b0;
        if (a[31:AddrW] == '0) model[a[AddrW-1:0]] = d;
    endtask

    // exp_edges counts clock edges from now until ready should be high.
    task automatic wait_ready(input string tag, input int exp_edges);
        int k = 0;
        while (!memory_ready && k < 20) begin
            tick();
            k++;
        end
        if (!memory_ready) begin
            check({tag, "_timeout"}, 32'(memory_ready), 32'd1);
            if (exp_q.size() > 0) exp_q.delete(0);
        end else begin
            check({tag, "_latency"}, 32'(k), 32'(exp_edges));
            check({tag, "_data"}, 32'(data_out), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic read_byte(input string tag, input logic [31:0] a);
        exp_q.push_back(exp_byte(a));
        addr           = a;
        memory_read_en = 1'b1;
        #1;
        check({tag, "_rdy_low"}, 32'(memory_ready), 32'd0);
        wait_ready(tag, Lat + 1);
    endtask

    task automatic idle();
        memory_read_en = 1'b0;
        #1;
        check("rdy_drop_on_rden_low", 32'(memory_ready), 32'd0);
        tick();
    endtask

    initial begin
        #12;
        check("rst_ready", 32'(memory_ready), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_conflict", 32'(conflict), 32'd0);
        rst_n = 1'b1;
        tick();

        load_write(32'h10, 8'h41);
        load_write(32'h20, 8'h12);
        load_write(32'h21, 8'h34);
        load_write(32'h30, 8'hC3);
        load_write(32'h41, 8'h3C);
        for (int i = 0; i < 8; i++) load_write(32'h60 + 32'(i), 8'($urandom_range(1, 255)));

        read_byte("rd10", 32'h10);
        idle();

        read_byte("rd20", 32'h20);
        read_byte("rd21_addr_change", 32'h21);
        idle();

        // CPU write to the address being held in READY must restart the read.
        read_byte("rd30", 32'h30);
        memory_write_en = 1'b1;
        data_in         = 8'h07;
        model[10'h30]   = 8'h07;
        exp_q.push_back(8'h07);
        tick();
        memory_write_en = 1'b0;
        check("wr_hit_rdy_drop", 32'(memory_ready), 32'd0);
        wait_ready("rd30_restart", Lat);
        idle();

        cpu_write(32'h50, 8'h5A);
        read_byte("wr_then_rd50", 32'h50);

        for (int i = 7; i >= 0; i--) read_byte("b2b", 32'h60 + 32'(i));
        idle();

        load_valid      = 1'b1;
        load_addr       = 32'h40;
        load_data       = 8'hAA;
        memory_write_en = 1'b1;
        addr            = 32'h41;
        data_in         = 8'h55;
        tick();
        load_valid      = 1'b0;
        memory_write_en = 1'b0;
        model[10'h40]   = 8'hAA;
        check("conflict_set", 32'(conflict), 32'd1);
        read_byte("rd40_loader_won", 32'h40);
        read_byte("rd41_cpu_dropped", 32'h41);
        idle();

        check("addr_err_clear", 32'(addr_err), 32'd0);
        read_byte("rd_oor", 32'h0000_0400);
        check("addr_err_oor_rd", 32'(addr_err), 32'd1);
        check("conflict_sticky", 32'(conflict), 32'd1);
        idle();

        // Reset while READY: ready must fall without a clock edge.
        read_byte("rd10_pre_rst", 32'h10);
        rst_n = 1'b0;
        #1;
        check("rst_async_ready", 32'(memory_ready), 32'd0);
        check("rst_async_data", 32'(data_out), 32'd0);
        check("rst_async_addr_err", 32'(addr_err), 32'd0);
        check("rst_async_conflict", 32'(conflict), 32'd0);
        rst_n = 1'b1;
        exp_q.push_back(exp_byte(32'h10));
        wait_ready("rd10_reaccept", Lat + 1);
        idle();

        memory_read_en = 1'b1;
        addr           = 32'h21;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_in_wait_ready", 32'(memory_ready), 32'd0);
        rst_n = 1'b1;
        exp_q.push_back(exp_byte(32'h21));
        wait_ready("rd21_after_wait_rst", Lat + 1);
        idle();

        cpu_write(32'h410, 8'hEE);
        check("addr_err_oor_wr", 32'(addr_err), 32'd1);
        read_byte("rd10_no_alias", 32'h10);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
